root4_iter: RTL
===============

Name: root4_iter

Overview:
- Inverse of the team's single-cycle p**4 datapath: computes floor(x^(1/4)) of an unsigned DATA_W-bit operand.
- Iterative and multi-cycle: binary search, MSB first, one root bit per iteration, two cycles per iteration (square, then fourth power).
- Sits behind the power unit's output stream (data_out/data_out_valid) as a checker/decoder, or stands alone on any valid-strobe source.

Parameters:
- DATA_W, 32, operand width; must be a multiple of 4.
- ROOT_W, DATA_W/4, result width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; deasserts synchronously to clk externally.
- data_in  input  DATA_W  operand; sampled only on acceptance.
- data_in_valid  input  1  operand strobe; single-cycle or held.
- data_in_ready  output  1  high in IDLE and DONE; acceptance = data_in_valid & data_in_ready at a rising edge.
- data_out  output  ROOT_W  floor 4th root; holds last result until next DONE.
- data_out_valid  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset (rst=0, async): state=IDLE, data_out=0, data_out_valid=0, data_in_ready=1; internal operand/root/square/bit index cleared.
- Reset mid-operation aborts immediately; no partial result or valid pulse emitted.
- Registers: op (DATA_W), root (ROOT_W), sq (2*ROOT_W), bit index (clog2(ROOT_W)).
- Candidate: cand = root | (1 << bit), combinational.
- IDLE: on acceptance, op<=data_in, root<=0, bit<=ROOT_W-1, go SQR.
- SQR: sq <= cand*cand (2*ROOT_W bits, no truncation); go QUAD.
- QUAD: quad = sq*sq (full 4*ROOT_W = DATA_W bits, no overflow since cand <= 2^ROOT_W-1).
  - If quad <= op, root <= cand.
  - If bit==0, go DONE; else bit <= bit-1, go SQR.
- DONE: data_out_valid=1 for exactly one cycle; data_out takes the final root on the QUAD->DONE edge.
  - On acceptance in DONE: load the new operand and go SQR, giving back-to-back throughput.
  - Otherwise go IDLE.
- Latency: acceptance at edge k; data_out_valid high during the cycle after edge k+2*ROOT_W (17 cycles for ROOT_W=8).
- Throughput: one result per 2*ROOT_W+1 cycles.
- data_in_valid while in SQR/QUAD: ignored, not queued, no error.
- data_in is a don't-care when not being accepted.
- Comparisons are unsigned.
- Boundaries:
  - op=0 gives 0.
  - op=2^DATA_W-1 gives 2^ROOT_W-1.
  - Exact 4th powers return the exact root.
  - op one below a 4th power returns root-1.

Optional Feature:
- Macro: ROOT4_ITER_EXACT_EN.
- Defined:
  - Extra port data_out_exact, output, 1 bit.
  - Registered high on the QUAD->DONE edge iff the final root^4 == op, tracked by an internal flag updated in QUAD.
  - Reset value 0; holds with data_out.
- Undefined: port and flag logic absent; all other behaviour identical.

Test Plan:
- Reset, then data_in=0 pulse -> data_out_valid 17 cycles after acceptance, data_out=0, exact=1.
- data_in=80 -> data_out=2, exact=0; then data_in=81 -> data_out=3, exact=1.
- data_in=4228250625 (255^4) -> data_out=255, exact=1; data_in=32'hFFFFFFFF -> data_out=255, exact=0.
- data_in=16 accepted, then data_in_valid=1 with data_in=625 at cycles 3..10 -> ignored; result 2; data_in_ready low during SQR/QUAD.
- data_in=65536 accepted, rst pulsed low at cycle 6 -> no data_out_valid; data_out=0, ready=1 immediately; next 65536 -> 16.
- Back-to-back: valid held high with 1, 256, 6561 -> results 1, 4, 9, one valid pulse every 17 cycles, no gaps.

Source files
------------

// File: rtl/root4_iter.sv
`default_nettype none
// ============================================================================
//  Module      : root4_iter
//  Description : Iterative floor(x^(1/4)) of an unsigned DATA_W-bit operand.
//                Binary search, MSB first, one root bit per two cycles
//                (square the candidate, then square again for the 4th power).
//                Optional macro ROOT4_ITER_EXACT_EN adds data_out_exact,
//                set when the returned root raised to the 4th equals data_in.
//                DATA_W must be a multiple of 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module root4_iter #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,             // asynchronous, active-low
    input  logic [DATA_W-1:0]   data_in,
    input  logic                data_in_valid,
    output logic                data_in_ready,
    output logic [DATA_W/4-1:0] data_out,
    output logic                data_out_valid
`ifdef ROOT4_ITER_EXACT_EN
    ,
    output logic                data_out_exact
`endif
);

    localparam int c_ROOT_W = DATA_W / 4;
    localparam int c_BIT_W  = (c_ROOT_W > 1) ? $clog2(c_ROOT_W) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SQR  = 2'd1;
    localparam logic [1:0] c_ST_QUAD = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]            r_state;
    logic [DATA_W-1:0]     r_op;
    logic [c_ROOT_W-1:0]   r_root;
    logic [2*c_ROOT_W-1:0] r_sq;
    logic [c_BIT_W-1:0]    r_bit;

    logic [c_ROOT_W-1:0]   w_cand;
    logic [2*c_ROOT_W-1:0] w_cand_ext;
    logic [2*c_ROOT_W-1:0] w_sq_next;
    logic [DATA_W-1:0]     w_sq_ext;
    logic [DATA_W-1:0]     w_quad;
    logic                  w_fits;
    logic [c_ROOT_W-1:0]   w_root_next;
    logic                  w_accept;

    // Candidate root and its square / fourth power; widths are chosen so that
    // neither product can overflow (cand < 2^ROOT_W, so cand^4 < 2^DATA_W).
    assign w_cand      = r_root | (c_ROOT_W'(1) << r_bit);
    assign w_cand_ext  = {{c_ROOT_W{1'b0}}, w_cand};
    assign w_sq_next   = w_cand_ext * w_cand_ext;
    assign w_sq_ext    = {{(2*c_ROOT_W){1'b0}}, r_sq};
    assign w_quad      = w_sq_ext * w_sq_ext;
    assign w_fits      = (w_quad <= r_op);
    assign w_root_next = w_fits ? w_cand : r_root;

    assign data_in_ready  = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE);
    assign data_out_valid = (r_state == c_ST_DONE);
    assign w_accept       = data_in_valid && data_in_ready;

    // Control FSM and search datapath: DONE can accept directly for
    // back-to-back operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_ST_IDLE;
            r_op     <= '0;
            r_root   <= '0;
            r_sq     <= '0;
            r_bit    <= '0;
            data_out <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_accept) begin
                        r_op    <= data_in;
                        r_root  <= '0;
                        r_bit   <= c_BIT_W'(c_ROOT_W - 1);
                        r_state <= c_ST_SQR;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_SQR: begin
                    r_sq    <= w_sq_next;
                    r_state <= c_ST_QUAD;
                end
                c_ST_QUAD: begin
                    r_root <= w_root_next;
                    if (r_bit == '0) begin
                        data_out <= w_root_next;
                        r_state  <= c_ST_DONE;
                    end else begin
                        r_bit   <= r_bit - 1'b1;
                        r_state <= c_ST_SQR;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

`ifdef ROOT4_ITER_EXACT_EN
    logic r_exact;
    logic w_exact_next;

    // Root 0 is never tried as a candidate, so the zero operand seeds the flag
    // at acceptance; any nonzero root was accepted on an iteration where its
    // fourth power was compared against the operand.
    assign w_exact_next = r_exact || (w_quad == r_op);

    // Exactness flag, published alongside data_out on the QUAD->DONE edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exact        <= 1'b0;
            data_out_exact <= 1'b0;
        end else begin
            if (w_accept) begin
                r_exact <= (data_in == '0);
            end else if (r_state == c_ST_QUAD) begin
                r_exact <= w_exact_next;
                if (r_bit == '0) begin
                    data_out_exact <= w_exact_next;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire
